// File: rtl/simplenet_weight_loader.sv
`default_nettype none
// ============================================================================
// simplenet_weight_loader
//   Serial-to-parallel loader for the nine simpleNet weights.
//   Words are staged in a shadow bank and committed atomically.
//   Rev 1.0 - initial release
// ============================================================================
module simplenet_weight_loader #(
  parameter int W_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WIDTH-1:0] in_data,
  input  logic               in_last,
  output logic [W_WIDTH-1:0] w0,
  output logic [W_WIDTH-1:0] w1,
  output logic [W_WIDTH-1:0] w2,
  output logic [W_WIDTH-1:0] w3,
  output logic [W_WIDTH-1:0] w4,
  output logic [W_WIDTH-1:0] w5,
  output logic [W_WIDTH-1:0] w6,
  output logic [W_WIDTH-1:0] w7,
  output logic [W_WIDTH-1:0] w8,
  output logic               weights_valid,
  output logic               commit,
  output logic               frame_err
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMMIT = 2'd1,
    REJECT = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd8;

  state_t             state;
  state_t             state_nxt;
  logic               run;
  logic [3:0]         idx;
  logic [3:0]         idx_nxt;
  logic               do_store;
  logic               do_commit;
  logic               at_end;
  logic [W_WIDTH-1:0] shadow [0:7];
  logic [W_WIDTH-1:0] bank   [0:8];

  assign at_end = (idx == LAST_IDX);

  // run holds in_ready low until the first clock edge after reset release,
  // so words presented while rst is high are never taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    commit    = 1'b0;
    frame_err = 1'b0;
    do_store  = 1'b0;
    do_commit = 1'b0;
    case (state)
      LOAD: begin
        in_ready = run;
        if (in_valid && run) begin
          if (at_end && in_last) begin
            do_commit = 1'b1;
            idx_nxt   = 4'd0;
            state_nxt = COMMIT;
          end else if (at_end || in_last) begin
            idx_nxt   = 4'd0;
            state_nxt = REJECT;
          end else begin
            do_store  = 1'b1;
            idx_nxt   = idx + 4'd1;
          end
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = LOAD;
      end
      REJECT: begin
        frame_err = 1'b1;
        state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // A rejected frame needs no shadow clear: every slot is rewritten before
  // the next frame can reach its commit word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
      end
    end else if (do_store) begin
      shadow[idx[2:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        bank[i] <= '0;
      end
      weights_valid <= 1'b0;
    end else if (do_commit) begin
      for (int i = 0; i < 8; i++) begin
        bank[i] <= shadow[i];
      end
      bank[8]       <= in_data;
      weights_valid <= 1'b1;
    end
  end

  assign w0 = bank[0];
  assign w1 = bank[1];
  assign w2 = bank[2];
  assign w3 = bank[3];
  assign w4 = bank[4];
  assign w5 = bank[5];
  assign w6 = bank[6];
  assign w7 = bank[7];
  assign w8 = bank[8];

endmodule
`default_nettype wire

// File: tb/tb_simplenet_weight_loader.sv
`default_nettype none
// ============================================================================
// tb_simplenet_weight_loader
//   Scoreboard bench: frame-level reference model feeds an expected-event
//   queue; a negedge monitor pops and compares on commit / frame_err.
//   Rev 1.0 - initial release
// ============================================================================
module tb_simplenet_weight_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic [3:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic       weights_valid;
  logic       commit;
  logic       frame_err;

  always #5 clk = ~clk;

  simplenet_weight_loader #(.W_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .w0           (w0),
    .w1           (w1),
    .w2           (w2),
    .w3           (w3),
    .w4           (w4),
    .w5           (w5),
    .w6           (w6),
    .w7           (w7),
    .w8           (w8),
    .weights_valid(weights_valid),
    .commit       (commit),
    .frame_err    (frame_err)
  );

  typedef struct {
    bit          is_commit;
    logic [35:0] bank;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sbq[$];
  logic [3:0]  cur[$];
  logic [35:0] vis_bank  = '0;
  bit          vis_valid = 1'b0;
  bit          checking  = 1'b0;

  function automatic logic [35:0] dut_bank();
    return {w0, w1, w2, w3, w4, w5, w6, w7, w8};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame rules: 9 words with last on the ninth commits; last early, or a
  // ninth word without last, rejects and leaves the active bank alone.
  task automatic model_accept(input logic [3:0] d, input bit last);
    exp_t e;
    cur.push_back(d);
    if (last && cur.size() == 9) begin
      e.is_commit = 1'b1;
      e.bank      = '0;
      for (int i = 0; i < 9; i++) e.bank[35-4*i -: 4] = cur[i];
      sbq.push_back(e);
      cur.delete();
    end else if (last || cur.size() == 9) begin
      e.is_commit = 1'b0;
      e.bank      = '0;
      sbq.push_back(e);
      cur.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (checking && !rst) begin
      if (commit || frame_err) begin
        if (sbq.size() == 0) begin
          check("unexpected_event", {commit, frame_err}, 2'b00);
        end else begin
          e = sbq.pop_front();
          check("event_kind", {commit, frame_err}, e.is_commit ? 2'b10 : 2'b01);
          check("ready_low_after_frame", in_ready, 1'b0);
          if (e.is_commit) begin
            vis_bank  = e.bank;
            vis_valid = 1'b1;
          end
        end
      end
      check("bank", dut_bank(), vis_bank);
      check("weights_valid", weights_valid, vis_valid);
    end
  end

  task automatic send_word(input logic [3:0] d, input bit last, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = in_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
    else model_accept(d, last);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] f[9], input int gap);
    for (int i = 0; i < 9; i++) send_word(f[i], i == 8, gap);
  endtask

  task automatic model_reset();
    cur.delete();
    sbq.delete();
    vis_bank  = '0;
    vis_valid = 1'b0;
  endtask

  logic [3:0] xor_f[9];
  logic [3:0] sev_f[9];
  logic [3:0] rnd_f[9];

  initial begin
    xor_f = '{4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3, 4'd2, 4'hE, 4'd1};
    sev_f = '{default: 4'd7};

    // Reset held with valid asserted: nothing accepted, outputs cleared.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bank", dut_bank(), 36'h0);
    check("rst_wvalid", weights_valid, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_pulses", {commit, frame_err}, 2'b00);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ready_before_first_edge", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_release", in_ready, 1'b1);
    checking = 1'b1;

    send_frame(xor_f, 0);
    send_frame(xor_f, 1);

    for (int i = 0; i < 5; i++) send_word(4'($urandom), i == 4, 0);
    send_frame(sev_f, 0);

    for (int i = 0; i < 9; i++) send_word(4'h8, 1'b0, 0);
    send_frame(xor_f, 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 4; i++) send_word(4'd3, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_bank", dut_bank(), 36'h0);
    check("midrst_wvalid", weights_valid, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) rnd_f[i] = 4'($urandom);
    send_frame(rnd_f, 0);

    // Random mix of good, early-last and missing-last frames with gaps.
    for (int fr = 0; fr < 40; fr++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 9));
      if (kind < 6) begin
        for (int i = 0; i < 9; i++) rnd_f[i] = 4'($urandom);
        send_frame(rnd_f, int'($urandom_range(0, 2)));
      end else if (kind < 8) begin
        len = int'($urandom_range(1, 8));
        for (int i = 0; i < len; i++)
          send_word(4'($urandom), i == len - 1, int'($urandom_range(0, 2)));
      end else begin
        for (int i = 0; i < 9; i++)
          send_word(4'($urandom), 1'b0, int'($urandom_range(0, 2)));
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
